fifo_ctrl: RTL
==============

# fifo_ctrl

Single-clock FIFO controller that sequences a dual-port FIFO memory with synchronous write and combinational read. It owns the write and read pointers and generates the memory write enable and addresses. It presents valid/ready handshakes to producer and consumer, plus fill-level and threshold status. It sits between producer/consumer logic and the memory instance; data never passes through this block.

## Interface

Parameters:
- ADDRWIDTH, default 4: memory address width; DEPTH = 1<<ADDRWIDTH entries.
- AFULL_THRESH, default 12: almost_full asserts when level >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, default 4: almost_empty asserts when level <= this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr_valid  in  1  producer has a word to push.
- wr_ready  out  1  controller can accept a push this cycle.
- rd_valid  out  1  memory word at mem_raddr is valid head-of-queue.
- rd_ready  in  1  consumer takes the head word this cycle.
- mem_wclken  out  1  memory write enable.
- mem_wfull  out  1  full indication to the memory write gate.
- mem_waddr  out  ADDRWIDTH  memory write address.
- mem_raddr  out  ADDRWIDTH  memory read address.
- level  out  ADDRWIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.

## Operation

- State consists of wptr and rptr, each ADDRWIDTH+1 bits, wrapping modulo 2^(ADDRWIDTH+1). mem_waddr = wptr[ADDRWIDTH-1:0]; mem_raddr = rptr[ADDRWIDTH-1:0].
- empty = (wptr == rptr). full = MSBs differ and the low ADDRWIDTH bits are equal. level = wptr - rptr, computed at ADDRWIDTH+1 bits.
- push = wr_valid & wr_ready. wr_ready = !full. mem_wclken = push. mem_wfull = full.
- pop = rd_valid & rd_ready. rd_valid = !empty.
- On push, wptr increments. On pop, rptr increments. Simultaneous push and pop are both performed, and level is unchanged.
- At full, wr_ready = 0 even if a pop occurs the same cycle; there is no full bypass.
- At empty, rd_valid = 0 even if a push occurs the same cycle; there is no empty bypass.
- flush has priority over push and pop: wptr and rptr are cleared to 0, and the memory is not written that cycle.
  - wr_ready and rd_valid remain combinational from the pre-flush state; the producer must treat a push during flush as discarded.
  - mem_wclken is forced to 0 while flush = 1.
- reset behaves the same as flush, and reset has priority over flush.
- almost_full and almost_empty are registered. They are computed from the next-state level, so they are aligned with level.
- Memory contents are never cleared. Stale data beyond rptr is unreachable.

## Timing

- Reset values:
  - wptr = rptr = 0, so level = 0, empty = 1, full = 0.
  - wr_ready = 1 once reset deasserts; while reset = 1, mem_wclken = 0.
  - rd_valid = 0, almost_full = 0, almost_empty = 1 (when AEMPTY_THRESH >= 0), mem_waddr = mem_raddr = 0.
- Write-to-read latency is 1 cycle: a word pushed at edge N is presented with rd_valid = 1 in the cycle after edge N.
- The memory captures the write at the same edge where wptr advances, so head data is stable before rd_valid rises.
- Pop takes effect at the clock edge. The next head word appears combinationally after mem_raddr updates.
- level, full, empty and both threshold flags update at the same edge as the pointer change. None lag by an extra cycle.
- Pointer wrap: after 2^(ADDRWIDTH+1) pushes, wptr returns to 0 with no discontinuity in level.
- wr_ready and rd_valid depend only on registered state, with no combinational path from wr_valid or rd_ready.

## Test plan

- Reset with DEPTH=16: hold reset 3 cycles -> level=0, empty=1, full=0, rd_valid=0, wr_ready=1, almost_empty=1, almost_full=0, mem_wclken=0.
- Fill: push 16 words 0x00..0x0F back-to-back -> wr_ready drops on the cycle after the 16th push; level=16, full=1; almost_full rises as level goes 11->12; a 17th wr_valid produces no mem_wclken.
- Drain: from full, rd_ready=1 for 16 cycles -> mem_raddr walks 0..15; rd_valid falls after the 16th pop; level=0; almost_empty rises as level goes 5->4.
- Simultaneous: at level=8, push and pop together for 40 cycles -> level stays 8; both pointers wrap past 31->0; FIFO order is preserved against a scoreboard.
- Boundaries: at full, pop and wr_valid together -> pop accepted, push rejected, level=15. At empty, push and rd_ready together -> no pop, level=1, rd_valid=1 next cycle.
- Flush mid-stream: at level=10 with wr_valid=1 and rd_ready=1, assert flush for 1 cycle -> next cycle level=0, empty=1, no memory write that cycle. Assert reset and flush together -> reset values.

Source files
------------

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl
//  Purpose  : Single-clock FIFO pointer/handshake controller for an external
//             dual-port memory (sync write, combinational read).
//  Revision : 1.0
// ============================================================================
module fifo_ctrl #(
    parameter int ADDRWIDTH     = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 mem_wclken,
    output logic                 mem_wfull,
    output logic [ADDRWIDTH-1:0] mem_waddr,
    output logic [ADDRWIDTH-1:0] mem_raddr,
    output logic [ADDRWIDTH:0]   level,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty
);

    localparam logic [ADDRWIDTH:0] c_one    = (ADDRWIDTH+1)'(1);
    localparam logic [ADDRWIDTH:0] c_afull  = (ADDRWIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDRWIDTH:0] c_aempty = (ADDRWIDTH+1)'(AEMPTY_THRESH);

    logic [ADDRWIDTH:0] r_wptr;
    logic [ADDRWIDTH:0] r_rptr;
    logic               r_afull;
    logic               r_aempty;

    logic               w_full;
    logic               w_empty;
    logic               w_clear;
    logic               w_push;
    logic               w_pop;
    logic [ADDRWIDTH:0] w_level;
    logic [ADDRWIDTH:0] w_wptr_nxt;
    logic [ADDRWIDTH:0] w_rptr_nxt;
    logic [ADDRWIDTH:0] w_level_nxt;

    // The extra pointer MSB distinguishes full from empty when the addresses match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDRWIDTH] != r_rptr[ADDRWIDTH]) &&
                     (r_wptr[ADDRWIDTH-1:0] == r_rptr[ADDRWIDTH-1:0]);
    assign w_level = r_wptr - r_rptr;

    // Handshakes look only at registered state; a clearing cycle discards both sides.
    assign w_clear = reset | flush;
    assign w_push  = wr_valid & ~w_full  & ~w_clear;
    assign w_pop   = rd_ready & ~w_empty & ~w_clear;

    assign w_wptr_nxt  = w_clear ? '0 : (w_push ? r_wptr + c_one : r_wptr);
    assign w_rptr_nxt  = w_clear ? '0 : (w_pop  ? r_rptr + c_one : r_rptr);
    assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            // Flags track the level they will sit beside after this edge.
            r_afull  <= (w_level_nxt >= c_afull);
            r_aempty <= (w_level_nxt <= c_aempty);
        end
    end

    assign wr_ready     = ~w_full;
    assign rd_valid     = ~w_empty;
    assign mem_wclken   = w_push;
    assign mem_wfull    = w_full;
    assign mem_waddr    = r_wptr[ADDRWIDTH-1:0];
    assign mem_raddr    = r_rptr[ADDRWIDTH-1:0];
    assign level        = w_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;

endmodule
`default_nettype wire
